// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: canonical NOP, major opcodes and the
// fetch-stage state encoding.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] ALU_R     = 7'b0110011;
   localparam logic [6:0] ALU_I     = 7'b0010011;
   localparam logic [6:0] BRANCH_EQ = 7'b1100011;
   localparam logic [6:0] JUMP      = 7'b1101111;
   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] STORE     = 7'b0100011;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load; with no control
// asserted a bubble (invalid NOP, pc kept) is written.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_W   = 64,
   parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              hold,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic [31:0]       load_instr,
   output logic              if_id_valid,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [31:0]       if_id_instr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= NOP_WORD;
      end else if (flush || (!hold && !load)) begin
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_WORD;
      end else if (!hold) begin
         if_id_valid <= 1'b1;
         if_id_pc    <= load_pc;
         if_id_instr <= load_instr;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, skid buffer
// for responses that land during a stall, and redirect draining.
module fetch_stage #(
   parameter int unsigned       ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [31:0]       imem_rdata,
   output logic              if_id_valid,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [31:0]       if_id_instr,
   output logic [6:0]        opcode
);
   import riscv_pkg::*;

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] pc, pc_next;
   logic [ADDR_W-1:0] req_addr, req_addr_next;
   logic [31:0]       hold_instr, hold_instr_next;
   logic              ifid_flush, ifid_hold, ifid_load;
   logic [31:0]       ifid_instr;
   logic [ADDR_W-1:0] redirect_aligned;
   logic [ADDR_W-1:0] pc_inc;

   assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
   assign pc_inc           = pc + ADDR_W'(4);

   // Next-state, PC and IF/ID control
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      req_addr_next   = req_addr;
      hold_instr_next = hold_instr;
      ifid_flush      = 1'b0;
      ifid_hold       = 1'b1;
      ifid_load       = 1'b0;
      ifid_instr      = imem_rdata;
      case (state)
         ST_RESET: begin
            req_addr_next = pc;
            state_next    = ST_FETCH;
         end
         ST_FETCH: begin
            if (redirect) begin
               pc_next    = redirect_aligned;
               ifid_flush = 1'b1;
               // A live response can be dropped on the spot; otherwise wait it out
               if (imem_valid) req_addr_next = redirect_aligned;
               else            state_next    = ST_DRAIN;
            end else if (imem_valid) begin
               if (stall) begin
                  hold_instr_next = imem_rdata;
                  state_next      = ST_HOLD;
               end else begin
                  ifid_load     = 1'b1;
                  ifid_hold     = 1'b0;
                  pc_next       = pc_inc;
                  req_addr_next = pc_inc;
               end
            end else begin
               ifid_hold = stall;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_next       = redirect_aligned;
               req_addr_next = redirect_aligned;
               ifid_flush    = 1'b1;
               state_next    = ST_FETCH;
            end else if (!stall) begin
               ifid_load     = 1'b1;
               ifid_hold     = 1'b0;
               ifid_instr    = hold_instr;
               pc_next       = pc_inc;
               req_addr_next = pc_inc;
               state_next    = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (redirect) begin
               pc_next    = redirect_aligned;
               ifid_flush = 1'b1;
            end
            if (imem_valid) begin
               req_addr_next = redirect ? redirect_aligned : pc;
               state_next    = ST_FETCH;
            end
         end
         default: state_next = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_RESET;
         pc         <= RESET_PC;
         req_addr   <= RESET_PC;
         hold_instr <= NOP_INSTR;
         imem_req   <= 1'b0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         req_addr   <= req_addr_next;
         hold_instr <= hold_instr_next;
         imem_req   <= (state_next == ST_FETCH) || (state_next == ST_DRAIN);
      end
   end

   assign imem_addr = req_addr;
   assign opcode    = if_id_instr[6:0];

   if_id_reg #(
      .ADDR_W   (ADDR_W),
      .NOP_WORD (NOP_INSTR)
   ) u_if_id (
      .clk         (clk),
      .rst         (rst),
      .flush       (ifid_flush),
      .hold        (ifid_hold),
      .load        (ifid_load),
      .load_pc     (req_addr),
      .load_instr  (ifid_instr),
      .if_id_valid (if_id_valid),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/reset
// traffic against a variable-latency memory and an in-order PC-stream model.
`timescale 1ns/1ps
module tb_fetch_stage;
   import riscv_pkg::*;

   localparam int unsigned       ADDR_W   = 64;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   logic              clk = 1'b0;
   logic              rst, stall, redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_valid;
   logic [31:0]       imem_rdata;
   logic              if_id_valid;
   logic [ADDR_W-1:0] if_id_pc;
   logic [31:0]       if_id_instr;
   logic [6:0]        opcode;

   always #5 clk = ~clk;

   fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
      .if_id_instr(if_id_instr), .opcode(opcode)
   );

   int total = 0;
   int bad   = 0;

   // memory model
   bit                mem_busy = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   int                mem_wait;
   int                lat = 1;
   int                req_count = 0;

   // architectural model: next expected delivered PC
   logic [ADDR_W-1:0] exp_pc = RESET_PC;
   int                deliveries = 0;

   function automatic logic [31:0] mem_data(input logic [ADDR_W-1:0] a);
      if (a == 64'h0) return 32'h0050_0093;
      if (a == 64'h4) return 32'h0000_0033;
      return {a[26:2] ^ 25'h0ab_cde1, 7'b0110011};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: memory responds, inputs applied, edge, then model checks.
   task automatic run_cycle(input bit r, input bit s, input bit rd, input logic [ADDR_W-1:0] rpc);
      logic              pv;
      logic [ADDR_W-1:0] ppc;
      logic [31:0]       pin;
      rst = r; stall = s; redirect = rd; redirect_pc = rpc;
      if (r) begin
         mem_busy   = 1'b0;
         imem_valid = 1'b0;
      end else begin
         if (mem_busy && imem_valid) mem_busy = 1'b0;
         imem_valid = 1'b0;
         if (mem_busy) begin
            chk("req_held", 64'(imem_req), 64'd1);
            chk("addr_stable", imem_addr, mem_addr);
            mem_wait--;
            if (mem_wait == 0) begin
               imem_valid = 1'b1;
               imem_rdata = mem_data(mem_addr);
            end
         end else if (imem_req === 1'b1) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_wait = lat;
            req_count++;
         end
      end
      pv = if_id_valid; ppc = if_id_pc; pin = if_id_instr;
      @(posedge clk);
      #1;
      if (r) begin
         chk("rst_valid", 64'(if_id_valid), 64'd0);
         chk("rst_pc", if_id_pc, 64'd0);
         chk("rst_instr", 64'(if_id_instr), 64'(NOP_INSTR));
         chk("rst_opcode", 64'(opcode), 64'(7'b0010011));
         chk("rst_req", 64'(imem_req), 64'd0);
         exp_pc = RESET_PC;
      end else if (rd) begin
         chk("flush_valid", 64'(if_id_valid), 64'd0);
         chk("flush_instr", 64'(if_id_instr), 64'(NOP_INSTR));
         exp_pc = rpc & ~64'h3;
      end else if (s) begin
         chk("stall_valid", 64'(if_id_valid), 64'(pv));
         chk("stall_pc", if_id_pc, ppc);
         chk("stall_instr", 64'(if_id_instr), 64'(pin));
      end else if (if_id_valid) begin
         chk("deliv_pc", if_id_pc, exp_pc);
         chk("deliv_instr", 64'(if_id_instr), 64'(mem_data(exp_pc)));
         chk("deliv_opcode", 64'(opcode), 64'(mem_data(exp_pc) & 32'h7f));
         exp_pc = exp_pc + 64'd4;
         deliveries++;
      end else begin
         chk("bubble_instr", 64'(if_id_instr), 64'(NOP_INSTR));
      end
   endtask

   bit                r_r, r_s, r_rd, after_rst;
   logic [ADDR_W-1:0] r_pc;

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_valid = 1'b0; imem_rdata = '0;

      run_cycle(1, 0, 0, 0);
      run_cycle(1, 0, 0, 0);

      // reset release, 1-cycle memory
      lat = 1;
      run_cycle(0, 0, 0, 0);
      chk("first_req", 64'(imem_req), 64'd1);
      chk("first_addr", imem_addr, RESET_PC);
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      chk("d1_valid", 64'(if_id_valid), 64'd1);
      chk("d1_pc", if_id_pc, 64'd0);
      chk("d1_opcode", 64'(opcode), 64'(7'b0010011));
      chk("d1_next_addr", imem_addr, 64'd4);

      // stall coinciding with the response for address 4
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 1, 0, 0);
      chk("hold_req", 64'(imem_req), 64'd0);
      run_cycle(0, 1, 0, 0);
      run_cycle(0, 1, 0, 0);
      chk("hold_ifid_valid", 64'(if_id_valid), 64'd0);
      run_cycle(0, 0, 0, 0);
      chk("rel_valid", 64'(if_id_valid), 64'd1);
      chk("rel_pc", if_id_pc, 64'd4);
      chk("rel_instr", 64'(if_id_instr), 64'h33);
      chk("req_count", 64'(req_count), 64'd2);
      chk("rel_next_addr", imem_addr, 64'd8);

      // redirect while the request to 8 is outstanding (3-cycle memory)
      lat = 3;
      run_cycle(0, 0, 1, 64'h100);
      chk("drain_req", 64'(imem_req), 64'd1);
      chk("drain_addr", imem_addr, 64'd8);
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      chk("redir_addr", imem_addr, 64'h100);
      chk("stale_dropped", 64'(if_id_valid), 64'd0);
      lat = 1;
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      chk("redir_valid", 64'(if_id_valid), 64'd1);
      chk("redir_pc", if_id_pc, 64'h100);

      // redirect together with stall while in HOLD
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 1, 0, 0);
      chk("hold2_req", 64'(imem_req), 64'd0);
      run_cycle(0, 1, 1, 64'h200);
      chk("hold_redir_valid", 64'(if_id_valid), 64'd0);
      chk("hold_redir_req", 64'(imem_req), 64'd1);
      chk("hold_redir_addr", imem_addr, 64'h200);
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      chk("hold_redir_pc", if_id_pc, 64'h200);

      // redirect coincident with a response; low address bits ignored
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 1, 64'h303);
      chk("coinc_addr", imem_addr, 64'h300);
      chk("coinc_req", 64'(imem_req), 64'd1);
      run_cycle(0, 0, 0, 0);
      run_cycle(0, 0, 0, 0);
      chk("coinc_pc", if_id_pc, 64'h300);

      // reset in the middle of DRAIN
      lat = 3;
      run_cycle(0, 0, 1, 64'h40);
      run_cycle(1, 0, 1, 64'h40);
      run_cycle(0, 0, 0, 64'h40);
      chk("post_rst_req", 64'(imem_req), 64'd1);
      chk("post_rst_addr", imem_addr, RESET_PC);

      // random traffic
      after_rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r_r  = ($urandom_range(0, 199) == 0);
         r_s  = ($urandom_range(0, 9) < 3);
         r_rd = !after_rst && ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 2))
            0:       r_pc = 64'($urandom_range(0, 255)) << 2;
            1:       r_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            default: r_pc = {$urandom, $urandom};
         endcase
         lat = $urandom_range(1, 4);
         run_cycle(r_r, r_s, r_rd, r_pc);
         after_rst = r_r;
      end
      chk("liveness", 64'(deliveries > 100), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
